// File: rtl/pwm_duty_ramp_ctrl.sv
// pwm_duty_ramp_ctrl: ramps a PWM duty-cycle register toward a target via paced register writes.
// Ports:
//   clk, rst                     - clock and synchronous active-high reset
//   start, target_duty, step,    - ramp request and its parameters (latched on accepted start)
//   interval
//   abort                        - early stop request (active only with PWM_RAMP_ABORT_EN defined)
//   wr_valid, wr_ready,          - register-write handshake toward the register file
//   wr_addr, wr_data
//   duty_cur                     - last duty value accepted by the register file
//   busy, done                   - not-idle status and one-cycle completion pulse
// Configuration macro: PWM_RAMP_ABORT_EN enables the abort feature.
module pwm_duty_ramp_ctrl #(
    parameter logic [7:0] DUTY_ADDR = 8'h04
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  target_duty,
    input  logic [7:0]  step,
    input  logic [15:0] interval,
    input  logic        abort,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic [7:0]  duty_cur,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, WRITE, WAIT, DONE} state_t;
    state_t state, state_nxt;
    logic [7:0]  tgt, stp, nxt;
    logic [15:0] ivl, cnt;
    logic [8:0]  sum, dif;
    logic        hs, ab_wr, ab_wt;

    assign hs       = wr_valid & wr_ready;
    assign wr_valid = state == WRITE;
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign wr_addr  = DUTY_ADDR;
    assign wr_data  = wr_valid ? nxt : 8'd0;

    // 9-bit arithmetic: sum[8] flags overflow, dif[8] flags borrow; both saturate at the target.
    always_comb begin
        sum = {1'b0, duty_cur} + {1'b0, stp};
        dif = {1'b0, duty_cur} - {1'b0, stp};
        nxt = duty_cur < tgt ? (sum > {1'b0, tgt} ? tgt : sum[7:0])
                             : ((dif[8] || dif[7:0] < tgt) ? tgt : dif[7:0]);
    end

`ifdef PWM_RAMP_ABORT_EN
    // An abort seen during WRITE is remembered until the pending handshake completes.
    logic abort_pend;
    assign ab_wr = abort | abort_pend;
    assign ab_wt = abort;
    always_ff @(posedge clk) begin
        if (rst)
            abort_pend <= 1'b0;
        else if (state == WRITE)
            abort_pend <= hs ? 1'b0 : (abort_pend | abort);
        else
            abort_pend <= 1'b0;
    end
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign ab_wr = 1'b0;
    assign ab_wt = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = target_duty != duty_cur ? WRITE : DONE;
            WRITE:   if (hs) state_nxt = ab_wr ? IDLE : (nxt == tgt ? DONE : WAIT);
            WAIT:    state_nxt = ab_wt ? IDLE : (cnt == 16'd0 ? WRITE : WAIT);
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            duty_cur <= 8'd0;
            tgt      <= 8'd0;
            stp      <= 8'd0;
            ivl      <= 16'd0;
            cnt      <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                tgt <= target_duty;
                stp <= step == 8'd0 ? 8'd1 : step;
                ivl <= interval;
            end
            if (hs) begin
                duty_cur <= nxt;
                cnt      <= ivl;
            end else if (state == WAIT && cnt != 16'd0) begin
                cnt <= cnt - 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// tb_pwm_duty_ramp_ctrl: scoreboard bench for pwm_duty_ramp_ctrl with directed ramps.
module tb_pwm_duty_ramp_ctrl;
    logic        clk = 0, rst = 1, start = 0, abort = 0, wr_ready = 1;
    logic [7:0]  target_duty = 0, step = 0;
    logic [15:0] interval = 0;
    logic        wr_valid, busy, done;
    logic [7:0]  wr_addr, wr_data, duty_cur;

    typedef struct {bit kind; logic [7:0] d; int gap;} ev_t;
    ev_t q[$];
    int  errors = 0, checks = 0, cyc = 0, last_ev = 0;

    pwm_duty_ramp_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .target_duty(target_duty), .step(step),
        .interval(interval), .abort(abort), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .duty_cur(duty_cur), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic on_ev(input bit k, input logic [7:0] d);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got data %0d at cycle %0d expected no event", k ? "done" : "write", d, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != k || (!k && e.d != d) || (e.gap >= 0 && cyc - last_ev != e.gap)) begin
                errors++;
                $display("FAIL event: got kind %0d data %0d gap %0d expected kind %0d data %0d gap %0d",
                         k, d, cyc - last_ev, e.kind, e.d, e.gap);
            end
        end
        last_ev = cyc;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid && wr_ready) begin
                chk("wr_addr", wr_addr, 8'h04);
                on_ev(0, wr_data);
            end
            if (done) on_ev(1, 8'd0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expw(input logic [7:0] d, input int gap);
        q.push_back('{kind: 1'b0, d: d, gap: gap});
    endtask

    task automatic expd(input int gap);
        q.push_back('{kind: 1'b1, d: 8'd0, gap: gap});
    endtask

    task automatic go(input logic [7:0] t, input logic [7:0] s, input logic [15:0] i);
        target_duty = t; step = s; interval = i; start = 1;
        last_ev = cyc;
        tick;
        start = 0;
    endtask

    task automatic drain(input string n);
        int k;
        for (k = 0; k < 300 && (q.size() != 0 || busy); k++) tick;
        chk({n, "_drain_left"}, q.size(), 0);
        tick; tick;
    endtask

    initial begin
        tick; tick;
        chk("rst_duty_cur", duty_cur, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 0;
        tick;

        expw(30, 1); expw(60, 4); expw(90, 4); expw(100, 4); expd(1);
        go(100, 30, 2);
        chk("up_busy", busy, 1);
        drain("up");
        chk("up_duty", duty_cur, 100);

        expw(250, 1); expd(1);
        go(250, 200, 0);
        drain("to250");
        expw(150, 1); expw(50, 3); expw(5, 3); expd(1);
        go(5, 100, 1);
        drain("down");
        chk("down_duty", duty_cur, 5);

        expw(200, 1); expd(1);
        go(200, 255, 0);
        drain("to200");
        expw(255, 1); expd(1);
        go(255, 200, 3);
        drain("ovf");
        chk("ovf_duty", duty_cur, 255);

        wr_ready = 0;
        expw(205, -1); expw(155, 2); expw(105, 2); expw(100, 2); expd(1);
        go(100, 50, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", wr_valid, 1);
            chk("bp_data", wr_data, 205);
            chk("bp_duty", duty_cur, 255);
            tick;
        end
        wr_ready = 1;
        drain("bp");
        chk("bp_final", duty_cur, 100);

        expd(-1);
        go(100, 7, 4);
        chk("noop_valid", wr_valid, 0);
        drain("noop");
        chk("noop_duty", duty_cur, 100);

        wr_ready = 0;
        go(50, 10, 0);
        tick;
        chk("rstw_valid_before", wr_valid, 1);
        rst = 1;
        tick;
        chk("rstw_valid", wr_valid, 0);
        chk("rstw_duty", duty_cur, 0);
        chk("rstw_busy", busy, 0);
        rst = 0;
        wr_ready = 1;
        tick;

        expw(1, 1); expw(2, 2); expw(3, 2); expd(1);
        go(3, 0, 0);
        drain("step0");
        chk("step0_duty", duty_cur, 3);

`ifdef PWM_RAMP_ABORT_EN
        expw(13, 1);
        go(200, 10, 5);
        tick;
        abort = 1;
        tick;
        abort = 0;
        chk("abort_busy", busy, 0);
        chk("abort_duty", duty_cur, 13);
        drain("abort");
`else
        expw(13, 1); expw(23, 7); expw(33, 7); expd(1);
        go(33, 10, 5);
        tick;
        abort = 1;
        tick;
        abort = 0;
        chk("noabort_busy", busy, 1);
        drain("noabort");
        chk("noabort_duty", duty_cur, 33);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
